gcd_datapath: RTL

- Operand/arithmetic stage paired with the GCD control FSM. It captures two operands through a valid/ready handshake and runs subtractive Euclid while the FSM's compute flag is high.
- It returns the two status signals the FSM needs: compare_zero and compute_enable.
- It presents the result on a valid/ready output once the FSM reports finish.
- The FSM's finish state is terminal, so one computation runs per reset.

---
 rtl/gcd_datapath.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand/arithmetic stage for the GCD controller.
// Captures two operands, runs subtractive Euclid while the controller is in
// COMPUTE, reports zero/enable status back to it and hands the result out
// over a valid/ready port. One computation runs per reset.
// Optional build macro GCD_ITER_COUNT_EN adds iter_cnt_o, a saturating count
// of the iterations that actually changed a register.
module gcd_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             operand_valid_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             operand_ready_o,
  input  logic             flag_init_i,
  input  logic             flag_compute_i,
  input  logic             flag_finish_i,
  output logic             compute_enable_o,
  output logic             compare_zero_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
`ifdef GCD_ITER_COUNT_EN
  output logic [WIDTH-1:0] iter_cnt_o,
`endif
  output logic             busy_o
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;

  logic w_a_zero;
  logic w_b_zero;
  logic w_capture;
  logic w_iterate;
  logic w_accept;

  assign w_a_zero  = (r_a == ZERO);
  assign w_b_zero  = (r_b == ZERO);
  assign w_capture = operand_valid_i && operand_ready_o;
  // Only an iteration that will really change a register counts; once either
  // register reaches zero the operands freeze even if COMPUTE lingers.
  assign w_iterate = flag_compute_i && (r_state == ST_LOADED) && !w_a_zero && !w_b_zero;
  assign w_accept  = result_valid_o && result_ready_i;

  // State register: async clear abandons any computation in flight.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: EMPTY -> LOADED on capture, LOADED -> DONE on result handoff.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_capture) begin
          w_state_nxt = ST_LOADED;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_LOADED: begin
        if (w_accept) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LOADED;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Outputs: status and handshake signals decoded from state and operands.
  always_comb begin
    operand_ready_o  = flag_init_i && (r_state == ST_EMPTY);
    compute_enable_o = (r_state == ST_LOADED) && !w_a_zero && !w_b_zero;
    compare_zero_o   = (r_state != ST_EMPTY) && (w_a_zero || w_b_zero);
    busy_o           = (r_state == ST_LOADED);
    result_valid_o   = flag_finish_i && (r_state == ST_LOADED) && compare_zero_o;
    if (r_state != ST_EMPTY) begin
      // With one register zero the OR is simply the surviving operand.
      result_o = r_a | r_b;
    end else begin
      result_o = ZERO;
    end
  end

  // Operand next value: load on capture, otherwise one subtractive step.
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (w_capture) begin
      w_a_nxt = operand_a_i;
      w_b_nxt = operand_b_i;
    end else if (w_iterate) begin
      if (r_a > r_b) begin
        w_a_nxt = r_a - r_b;
      end else if (r_b > r_a) begin
        w_b_nxt = r_b - r_a;
      end else begin
        // Equal operands: the GCD is reached, retire B so compare_zero rises.
        w_b_nxt = ZERO;
      end
    end else begin
      w_a_nxt = r_a;
      w_b_nxt = r_b;
    end
  end

  // Operand registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_a <= ZERO;
      r_b <= ZERO;
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_iter_cnt;
  logic [WIDTH-1:0] w_iter_cnt_nxt;

  // Iteration counter next value: clear on capture, saturating increment.
  always_comb begin
    w_iter_cnt_nxt = r_iter_cnt;
    if (w_capture) begin
      w_iter_cnt_nxt = ZERO;
    end else if (w_iterate && (r_iter_cnt != ONES)) begin
      w_iter_cnt_nxt = r_iter_cnt + ONE;
    end else begin
      w_iter_cnt_nxt = r_iter_cnt;
    end
  end

  // Iteration counter register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_iter_cnt <= ZERO;
    end else begin
      r_iter_cnt <= w_iter_cnt_nxt;
    end
  end

  assign iter_cnt_o = r_iter_cnt;
`endif

endmodule
